dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the word-addressed data memory: 1024 words, combinational read, synchronous word write on mem_write.
- Port 0 is the core load/store path; port 1 is the debug/loader path.
- Serialises requests with round-robin fairness and performs byte-strobed writes as read-modify-write sequences, because the memory only supports whole-word writes.
- Checks alignment and range, and returns registered read data on a valid/ready response channel.

Parameters:
- DEPTH, 1024: memory depth in words; legal word index is 0..DEPTH-1.
- AW, 10: word-index width, clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req_valid  in  1  port-0 request valid.
- m0_req_ready  out  1  port-0 request accepted this cycle.
- m0_req_we  in  1  1 = write, 0 = read.
- m0_req_addr  in  32  byte address.
- m0_req_wdata  in  32  write data.
- m0_req_strb  in  4  byte enables; bit i enables byte i (wdata[8i+7:8i]).
- m0_rsp_valid  out  1  port-0 response valid.
- m0_rsp_ready  in  1  port-0 response taken.
- m0_rsp_rdata  out  32  read data; 0 for writes and errors.
- m0_rsp_err  out  1  misaligned or out-of-range request.
- m1_*  same set as m0_*, for port 1.
- mem_address  out  32  to memory address; {word index, 2'b00}.
- mem_write_data  out  32  to memory write data.
- mem_write  out  1  memory write enable, one cycle per write.
- mem_read_data  in  32  from memory, combinational read.

Behaviour:
- Reset: state IDLE; rr_last = 1, so port 0 has priority on the first arbitration.
- Outputs under reset: all req_ready, rsp_valid, rsp_err and mem_write are 0; rsp_rdata, mem_address and mem_write_data are 0.
- Reset mid-operation: the transaction is abandoned, no response is issued, and mem_write is 0 from the reset cycle onward.
- State IDLE, arbitration:
  - If only one port's req_valid is high, that port wins.
  - If both are high, the port not equal to rr_last wins.
  - The winner's req_ready is 1 in the same cycle (combinational from req_valid and state). The loser's req_ready is 0.
  - On the handshake, latch we, addr, wdata, strb and port id; set rr_last = id; go to CHECK.
  - req_ready is 0 in every state other than IDLE.
- State CHECK:
  - err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - If err: go to RESP with rsp_err = 1 and rdata = 0; no memory access.
  - Otherwise go to ACCESS.
- State ACCESS:
  - mem_address = {addr[31:2], 2'b00}.
  - Read: capture mem_read_data into the rdata register; go to RESP.
  - Write with strb = 4'hF: mem_write = 1, mem_write_data = wdata; go to RESP.
  - Write with strb = 0: no write; go to RESP.
  - Write with a partial strb: capture mem_read_data into the merge register; go to MERGE.
- State MERGE:
  - mem_write = 1 at the same address.
  - Byte i of mem_write_data = strb[i] ? wdata byte i : merge-register byte i.
  - Go to RESP.
- State RESP:
  - The owning port's rsp_valid = 1, with rsp_rdata and rsp_err held stable.
  - Stay in RESP until that port's rsp_ready = 1, then go to IDLE.
  - The other port's rsp_valid stays 0.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency, with accept in cycle 0 and an immediately ready response:
  - Read or full write: rsp_valid in cycle 3.
  - Partial write: rsp_valid in cycle 4.
  - Error: rsp_valid in cycle 2.
- Throughput: one transaction in flight; no pipelining.
- mem_write is asserted only in ACCESS (full strobe) and MERGE. mem_address and mem_write_data are 0 outside ACCESS and MERGE.
- A read at an address written by the previous transaction returns the new data.

Test Plan:
- Reset with both ports valid, then release: port 0 granted first; port 1 granted next; the pattern alternates 0,1,0,1 while both stay valid.
- m0 full write addr 0x10, data 0xDEADBEEF, then m0 read 0x10: the memory-side write occurs in the ACCESS cycle (cycle 2 after accept) and rsp_valid is seen 3 cycles after accept; the read returns 0xDEADBEEF with rsp_err = 0.
- Partial write after the previous step: m1 write addr 0x10, strb 4'b0101, data 0x11223344.
  - A single mem_write pulse occurs, in MERGE.
  - A following read returns 0xDE22BE44.
- Errors: read at addr 0x13 gives rsp_err = 1 and rdata = 0 with no mem_write; write at addr 0x1000 (word 1024) gives rsp_err = 1 and memory is unchanged.
- Response backpressure: hold m0_rsp_ready = 0 for 5 cycles during a read.
  - rsp_valid and rsp_rdata stay stable.
  - m1_req_ready stays 0 until the cycle after the handshake.
- Reset asserted in MERGE: no mem_write in that cycle, no rsp_valid, and state is IDLE afterward.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the data memory, with byte-strobe read-modify-write, alignment/range checks and a registered valid/ready response per port
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_we,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_strb,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_we,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_strb,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [2:0] {IDLE, CHECK, ACCESS, MERGE, RESP} state_t;
  state_t state;
  logic rr_last, id, we, err, gnt0, gnt1, bad, acc, mrg, full;
  logic [31:0] addr, wdata, rdata, merge, merged;
  logic [3:0] strb;
  assign gnt0 = !rst && state == IDLE && m0_req_valid && (!m1_req_valid || rr_last);
  assign gnt1 = !rst && state == IDLE && m1_req_valid && (!m0_req_valid || !rr_last);
  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;
  assign bad = addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= DEPTH[31:0];
  assign full = strb == 4'hF;
  assign acc = !rst && state == ACCESS;
  assign mrg = !rst && state == MERGE;
  always_comb begin
    merged = merge;
    for (int i = 0; i < 4; i++)
      if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end
  assign mem_write = (acc && we && full) || mrg;
  assign mem_address = (acc || mrg) ? {{(30-AW){1'b0}}, addr[AW+1:2], 2'b00} : '0;
  assign mem_write_data = mrg ? merged : (acc && we && full) ? wdata : '0;
  assign m0_rsp_valid = !rst && state == RESP && !id;
  assign m1_rsp_valid = !rst && state == RESP && id;
  assign m0_rsp_rdata = m0_rsp_valid ? rdata : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata : '0;
  assign m0_rsp_err = m0_rsp_valid && err;
  assign m1_rsp_err = m1_rsp_valid && err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_last <= 1'b1;
      id <= 1'b0;
      we <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      wdata <= '0;
      strb <= '0;
      rdata <= '0;
      merge <= '0;
    end else begin
      case (state)
        IDLE: if (gnt0 || gnt1) begin
          id <= gnt1;
          rr_last <= gnt1;
          we <= gnt1 ? m1_req_we : m0_req_we;
          addr <= gnt1 ? m1_req_addr : m0_req_addr;
          wdata <= gnt1 ? m1_req_wdata : m0_req_wdata;
          strb <= gnt1 ? m1_req_strb : m0_req_strb;
          rdata <= '0;
          err <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          err <= bad;
          state <= bad ? RESP : ACCESS;
        end
        ACCESS: begin
          if (!we) rdata <= mem_read_data;
          if (we && !full && strb != 4'h0) merge <= mem_read_data;
          state <= (we && !full && strb != 4'h0) ? MERGE : RESP;
        end
        MERGE: state <= RESP;
        RESP: if (id ? m1_rsp_ready : m0_rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
